// File: rtl/key_entry_if.sv
// Keypad-side and register-side signals of the alarm clock key entry sequencer.
//   Inputs to the sequencer : one_second, key[3:0], alarm_button, time_button
//   Outputs of the sequencer: shift, load_new_a, load_new_c, show_new_time,
//                             show_a, entry_error
//   master: the side that drives keypad/timer inputs and receives strobes
//   slave : the sequencer itself
interface key_entry_if;
  logic       one_second;
  logic [3:0] key;
  logic       alarm_button;
  logic       time_button;
  logic       shift;
  logic       load_new_a;
  logic       load_new_c;
  logic       show_new_time;
  logic       show_a;
  logic       entry_error;

  modport master (
    output one_second, key, alarm_button, time_button,
    input  shift, load_new_a, load_new_c, show_new_time, show_a, entry_error
  );

  modport slave (
    input  one_second, key, alarm_button, time_button,
    output shift, load_new_a, load_new_c, show_new_time, show_a, entry_error
  );
endinterface

// File: rtl/key_entry_ctrl.sv
// Key entry sequencer for the alarm clock.
// Watches the decoded keypad code and the alarm/time buttons, emits one
// shift strobe per new key press, and a load strobe (or an error strobe when
// fewer than four digits were entered) when a button ends the entry. An entry
// left idle for TIMEOUT_SEC one-second ticks is abandoned.
// Ports:
//   clock : system clock, rising edge
//   reset : asynchronous, active-low
//   kif   : key_entry_if.slave (keypad/timer inputs, strobes and display selects)
// All outputs are registers loaded from the next-state decode, so they follow
// the state register in the same cycle and drop to 0 at once on reset.
module key_entry_ctrl #(
  parameter int unsigned TIMEOUT_SEC = 10,
  parameter logic [3:0]  NOKEY       = 4'hA
) (
  input  logic       clock,
  input  logic       reset,
  key_entry_if.slave kif
);

  localparam int unsigned CNT_W  = 3;
  localparam int unsigned IDLE_W = 4;
  localparam logic [CNT_W-1:0]  DIGITS_FULL = CNT_W'(4);
  localparam logic [IDLE_W-1:0] IDLE_LIMIT  = IDLE_W'(TIMEOUT_SEC);

  typedef enum logic [2:0] {
    S_SHOW_TIME,
    S_KEY_STORED,
    S_KEY_WAITED,
    S_KEY_ENTRY,
    S_SHOW_ALARM,
    S_SET_ALARM_TIME,
    S_SET_CURRENT_TIME
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_digit_cnt;
  logic [CNT_W-1:0]    w_digit_cnt_nxt;
  logic [IDLE_W-1:0]   r_idle_cnt;
  logic [IDLE_W-1:0]   w_idle_cnt_nxt;

  logic                r_shift;
  logic                r_load_new_a;
  logic                r_load_new_c;
  logic                r_show_new_time;
  logic                r_show_a;
  logic                r_entry_error;

  logic                w_shift_nxt;
  logic                w_load_new_a_nxt;
  logic                w_load_new_c_nxt;
  logic                w_show_new_time_nxt;
  logic                w_show_a_nxt;
  logic                w_entry_error_nxt;

  logic                w_is_digit;
  logic                w_timeout;
  logic                w_idle_now;
  logic                w_idle_nxt;

  // Codes above 9 and the NOKEY code all count as "no key".
  assign w_is_digit = (kif.key <= 4'd9) && (kif.key != NOKEY);
  assign w_timeout  = (r_idle_cnt == IDLE_LIMIT);

  // Idle counting only runs while waiting for release or for the next key.
  assign w_idle_now = (r_state == S_KEY_WAITED) || (r_state == S_KEY_ENTRY);
  assign w_idle_nxt = (w_state_nxt == S_KEY_WAITED) || (w_state_nxt == S_KEY_ENTRY);

  // State, digit counter and idle counter registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= S_SHOW_TIME;
      r_digit_cnt <= '0;
      r_idle_cnt  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_digit_cnt <= w_digit_cnt_nxt;
      r_idle_cnt  <= w_idle_cnt_nxt;
    end
  end

  // Next-state and counter update.
  always_comb begin
    w_state_nxt     = r_state;
    w_digit_cnt_nxt = r_digit_cnt;
    w_idle_cnt_nxt  = '0;

    case (r_state)
      S_SHOW_TIME: begin
        if (kif.alarm_button) begin
          w_state_nxt = S_SHOW_ALARM;
        end else if (w_is_digit) begin
          w_state_nxt     = S_KEY_STORED;
          w_digit_cnt_nxt = CNT_W'(1);
        end
      end
      S_KEY_STORED: begin
        w_state_nxt = S_KEY_WAITED;
      end
      S_KEY_WAITED: begin
        // Buttons are ignored until the key has been released.
        if (!w_is_digit) begin
          w_state_nxt = S_KEY_ENTRY;
        end else if (w_timeout) begin
          w_state_nxt = S_SHOW_TIME;
        end
      end
      S_KEY_ENTRY: begin
        // Alarm beats time, any button beats a digit, a digit beats timeout.
        if (kif.alarm_button) begin
          w_state_nxt = S_SET_ALARM_TIME;
        end else if (kif.time_button) begin
          w_state_nxt = S_SET_CURRENT_TIME;
        end else if (w_is_digit) begin
          w_state_nxt = S_KEY_STORED;
          if (r_digit_cnt < DIGITS_FULL) begin
            w_digit_cnt_nxt = r_digit_cnt + CNT_W'(1);
          end
        end else if (w_timeout) begin
          w_state_nxt = S_SHOW_TIME;
        end
      end
      S_SHOW_ALARM: begin
        if (!kif.alarm_button) begin
          w_state_nxt = S_SHOW_TIME;
        end
      end
      S_SET_ALARM_TIME,
      S_SET_CURRENT_TIME: begin
        w_state_nxt = S_SHOW_TIME;
      end
      default: begin
        w_state_nxt = S_SHOW_TIME;
      end
    endcase

    // Every entry into (or stay in) normal display forgets the digit count.
    if (w_state_nxt == S_SHOW_TIME) begin
      w_digit_cnt_nxt = '0;
    end

    // A tick coinciding with a new digit is dropped because the counter
    // restarts from KEY_STORED.
    if (w_idle_now && w_idle_nxt) begin
      if (kif.one_second && (r_idle_cnt < IDLE_LIMIT)) begin
        w_idle_cnt_nxt = r_idle_cnt + IDLE_W'(1);
      end else begin
        w_idle_cnt_nxt = r_idle_cnt;
      end
    end
  end

  // Output decode from the next state so registered outputs align with it.
  always_comb begin
    w_shift_nxt         = 1'b0;
    w_load_new_a_nxt    = 1'b0;
    w_load_new_c_nxt    = 1'b0;
    w_show_new_time_nxt = 1'b0;
    w_show_a_nxt        = 1'b0;
    w_entry_error_nxt   = 1'b0;

    case (w_state_nxt)
      S_KEY_STORED: begin
        w_shift_nxt         = 1'b1;
        w_show_new_time_nxt = 1'b1;
      end
      S_KEY_WAITED,
      S_KEY_ENTRY: begin
        w_show_new_time_nxt = 1'b1;
      end
      S_SHOW_ALARM: begin
        w_show_a_nxt = 1'b1;
      end
      S_SET_ALARM_TIME: begin
        w_load_new_a_nxt  = (w_digit_cnt_nxt == DIGITS_FULL);
        w_entry_error_nxt = (w_digit_cnt_nxt <  DIGITS_FULL);
      end
      S_SET_CURRENT_TIME: begin
        w_load_new_c_nxt  = (w_digit_cnt_nxt == DIGITS_FULL);
        w_entry_error_nxt = (w_digit_cnt_nxt <  DIGITS_FULL);
      end
      default: begin
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_shift         <= 1'b0;
      r_load_new_a    <= 1'b0;
      r_load_new_c    <= 1'b0;
      r_show_new_time <= 1'b0;
      r_show_a        <= 1'b0;
      r_entry_error   <= 1'b0;
    end else begin
      r_shift         <= w_shift_nxt;
      r_load_new_a    <= w_load_new_a_nxt;
      r_load_new_c    <= w_load_new_c_nxt;
      r_show_new_time <= w_show_new_time_nxt;
      r_show_a        <= w_show_a_nxt;
      r_entry_error   <= w_entry_error_nxt;
    end
  end

  assign kif.shift         = r_shift;
  assign kif.load_new_a    = r_load_new_a;
  assign kif.load_new_c    = r_load_new_c;
  assign kif.show_new_time = r_show_new_time;
  assign kif.show_a        = r_show_a;
  assign kif.entry_error   = r_entry_error;

endmodule

// File: tb/tb_key_entry_ctrl.sv
// Testbench for key_entry_ctrl: strobe events are predicted into a queue as
// stimulus is driven and compared as the DUT emits them; display levels and
// reset behaviour are checked directly against constants.
module tb_key_entry_ctrl;

  localparam logic [3:0] NOKEY = 4'hA;

  logic clock;
  logic reset;
  key_entry_if kif ();

  key_entry_ctrl dut (
    .clock (clock),
    .reset (reset),
    .kif   (kif)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];

  // Event code: {load_new_c, load_new_a, entry_error, shift, key-if-shift}.
  localparam logic [7:0] EV_LOAD_C = 8'h80;
  localparam logic [7:0] EV_LOAD_A = 8'h40;
  localparam logic [7:0] EV_ERROR  = 8'h20;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [5:0] outs();
    return {kif.shift, kif.load_new_a, kif.load_new_c,
            kif.show_new_time, kif.show_a, kif.entry_error};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Strobe monitor: every strobe cycle must match the next predicted event.
  always @(negedge clock) begin
    logic [7:0] obs;
    if (kif.shift || kif.load_new_a || kif.load_new_c || kif.entry_error) begin
      obs = {kif.load_new_c, kif.load_new_a, kif.entry_error, kif.shift,
             kif.shift ? kif.key : 4'h0};
      if (exp_q.size() == 0) chk("unexpected_strobe", 32'(obs), 32'h0);
      else                   chk("strobe", 32'(obs), 32'(exp_q.pop_front()));
    end
  end

  // Press digit d for 'hold' cycles, then NOKEY for 'gap' cycles.
  task automatic press(input logic [3:0] d, input int hold, input int gap);
    kif.key = d;
    exp_q.push_back({4'b0001, d});
    tick();
    chk("shift_first", 32'(kif.shift), 32'h1);
    chk("snt_stored", 32'(kif.show_new_time), 32'h1);
    for (int i = 1; i < hold; i++) begin
      tick();
      chk("shift_held", 32'(kif.shift), 32'h0);
      chk("snt_held", 32'(kif.show_new_time), 32'h1);
    end
    kif.key = NOKEY;
    for (int i = 0; i < gap; i++) begin
      tick();
      chk("snt_gap", 32'(kif.show_new_time), 32'h1);
    end
  endtask

  initial begin
    reset            = 1'b0;
    kif.key          = NOKEY;
    kif.one_second   = 1'b0;
    kif.alarm_button = 1'b0;
    kif.time_button  = 1'b0;
    #1;
    chk("rst_outs", 32'(outs()), 32'h0);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    chk("post_rst_outs", 32'(outs()), 32'h0);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_outs", 32'(outs()), 32'h0);
    end

    // Four digits then the time button: load the current time.
    press(4'd1, 5, 3);
    press(4'd2, 5, 3);
    press(4'd3, 5, 3);
    press(4'd4, 5, 3);
    exp_q.push_back(EV_LOAD_C);
    kif.time_button = 1'b1;
    tick();
    chk("load_c", 32'(kif.load_new_c), 32'h1);
    chk("snt_off_load", 32'(kif.show_new_time), 32'h0);
    kif.time_button = 1'b0;
    tick();
    chk("back_show_time", 32'(outs()), 32'h0);
    tick();

    // Two digits then alarm: refused, then a held button shows the alarm.
    press(4'd0, 2, 1);
    press(4'd7, 2, 1);
    exp_q.push_back(EV_ERROR);
    kif.alarm_button = 1'b1;
    tick();
    chk("err_strobe", 32'(kif.entry_error), 32'h1);
    chk("no_load_a", 32'(kif.load_new_a), 32'h0);
    tick();
    chk("err_back", 32'(outs()), 32'h0);
    tick();
    chk("held_show_a", 32'(kif.show_a), 32'h1);
    kif.alarm_button = 1'b0;
    tick();
    chk("show_a_rel", 32'(kif.show_a), 32'h0);

    // Key 5 held through 10 ticks: timeout back to SHOW_TIME, one shift.
    kif.key = 4'd5;
    exp_q.push_back({4'b0001, 4'd5});
    tick();
    tick();
    for (int i = 1; i <= 10; i++) begin
      kif.one_second = 1'b1;
      tick();
      kif.one_second = 1'b0;
      chk("to_hold", 32'(kif.show_new_time), 32'h1);
      tick();
    end
    chk("to_exit", 32'(kif.show_new_time), 32'h0);
    kif.key = NOKEY;
    tick();
    chk("to_idle", 32'(outs()), 32'h0);

    // Alarm button held 8 cycles: show_a for cycles 2..9.
    kif.alarm_button = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("show_a_on", 32'(kif.show_a), 32'h1);
    end
    kif.alarm_button = 1'b0;
    tick();
    chk("show_a_off", 32'(kif.show_a), 32'h0);

    // Five digits (saturating), then both buttons with a digit: alarm load.
    press(4'd9, 2, 2);
    press(4'd8, 2, 2);
    press(4'd6, 2, 2);
    press(4'd3, 2, 2);
    press(4'd2, 2, 2);
    exp_q.push_back(EV_LOAD_A);
    kif.key          = 4'd9;
    kif.alarm_button = 1'b1;
    kif.time_button  = 1'b1;
    tick();
    chk("both_load_a", 32'(kif.load_new_a), 32'h1);
    chk("both_no_c", 32'(kif.load_new_c), 32'h0);
    chk("btn_beats_digit", 32'(kif.shift), 32'h0);
    kif.key          = NOKEY;
    kif.alarm_button = 1'b0;
    kif.time_button  = 1'b0;
    tick();
    chk("both_back", 32'(outs()), 32'h0);

    // Reset asserted while in KEY_WAITED clears outputs immediately.
    kif.key = 4'd3;
    exp_q.push_back({4'b0001, 4'd3});
    tick();
    tick();
    chk("waited_snt", 32'(kif.show_new_time), 32'h1);
    reset = 1'b0;
    #1;
    chk("mid_rst_outs", 32'(outs()), 32'h0);
    kif.key = NOKEY;
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("mid_rst_release", 32'(outs()), 32'h0);
    tick();

    chk("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
